// File: rtl/ipv4_rx_decoder.sv
// IPv4 receive header parser: validates the header of a 32-bit word stream and
// forwards the payload words with a fresh start strobe and the decoded addresses.
module ipv4_rx_decoder #(
    parameter logic [7:0] PROTO_SEL    = 8'd17,
    parameter bit         CHECK_CHKSUM = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data,
    input  logic        start,
    output logic [31:0] src_ip,
    output logic [31:0] dest_ip,
    output logic [15:0] len_ip,
    output logic [31:0] data_out,
    output logic        start_out,
    output logic        wr_en,
    output logic        hdr_ok,
    output logic        fin,
    output logic        err
);

    localparam int unsigned SUM_W  = 21;
    localparam int unsigned PCNT_W = 15;
    localparam int unsigned WCNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HDR     = 2'd1,
        S_OPT     = 2'd2,
        S_PAYLOAD = 2'd3
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [WCNT_W-1:0]   r_wcnt,    w_wcnt_nxt;
    logic [3:0]          r_ver,     w_ver_nxt;
    logic [3:0]          r_ihl,     w_ihl_nxt;
    logic [15:0]         r_tlen,    w_tlen_nxt;
    logic [13:0]         r_frag,    w_frag_nxt;
    logic [7:0]          r_proto,   w_proto_nxt;
    logic [SUM_W-1:0]    r_sum,     w_sum_nxt;
    logic [31:0]         r_src_cap, w_src_cap_nxt;
    logic [31:0]         r_dst_cap, w_dst_cap_nxt;
    logic [PCNT_W-1:0]   r_pcnt,    w_pcnt_nxt;
    logic                r_first,   w_first_nxt;

    logic [31:0]         r_src_ip,    w_src_ip_nxt;
    logic [31:0]         r_dest_ip,   w_dest_ip_nxt;
    logic [15:0]         r_len_ip,    w_len_ip_nxt;
    logic [31:0]         r_data_out,  w_data_out_nxt;
    logic                r_start_out, w_start_out_nxt;
    logic                r_wr_en,     w_wr_en_nxt;
    logic                r_hdr_ok,    w_hdr_ok_nxt;
    logic                r_fin,       w_fin_nxt;
    logic                r_err,       w_err_nxt;

    logic [SUM_W-1:0]    w_sum_acc;
    logic [16:0]         w_fold1;
    logic [15:0]         w_fold2;
    logic                w_chk_ok;
    logic [15:0]         w_hdr_bytes;
    logic [15:0]         w_len;
    logic [PCNT_W-1:0]   w_pcnt;
    logic [31:0]         w_dst;
    logic                w_accept;
    logic                w_eval;

    // Running one's-complement sum including the current word, folded for the final test
    assign w_sum_acc   = r_sum + SUM_W'(data[31:16]) + SUM_W'(data[15:0]);
    assign w_fold1     = 17'(w_sum_acc[15:0]) + 17'(w_sum_acc[SUM_W-1:16]);
    assign w_fold2     = w_fold1[15:0] + 16'(w_fold1[16]);
    assign w_chk_ok    = !CHECK_CHKSUM || (w_fold2 == 16'hFFFF);
    assign w_hdr_bytes = 16'({r_ihl, 2'b00});
    assign w_len       = r_tlen - w_hdr_bytes;
    assign w_pcnt      = PCNT_W'((17'(w_len) + 17'd3) >> 2);
    assign w_dst       = (r_state == S_HDR) ? data : r_dst_cap;
    assign w_accept    = (r_ver == 4'd4) && (r_ihl >= 4'd5) && (r_tlen >= w_hdr_bytes) &&
                         (r_frag == 14'd0) && (r_proto == PROTO_SEL) && w_chk_ok;

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt     = r_state;
        w_wcnt_nxt      = r_wcnt;
        w_ver_nxt       = r_ver;
        w_ihl_nxt       = r_ihl;
        w_tlen_nxt      = r_tlen;
        w_frag_nxt      = r_frag;
        w_proto_nxt     = r_proto;
        w_sum_nxt       = r_sum;
        w_src_cap_nxt   = r_src_cap;
        w_dst_cap_nxt   = r_dst_cap;
        w_pcnt_nxt      = r_pcnt;
        w_first_nxt     = r_first;
        w_src_ip_nxt    = r_src_ip;
        w_dest_ip_nxt   = r_dest_ip;
        w_len_ip_nxt    = r_len_ip;
        w_data_out_nxt  = r_data_out;
        w_hdr_ok_nxt    = r_hdr_ok;
        w_start_out_nxt = 1'b0;
        w_wr_en_nxt     = 1'b0;
        w_fin_nxt       = 1'b0;
        w_err_nxt       = 1'b0;
        w_eval          = 1'b0;

        if (start) begin
            // A start in any state restarts the parse; an interrupted payload is reported
            w_err_nxt    = (r_state == S_PAYLOAD);
            w_hdr_ok_nxt = 1'b0;
            w_ver_nxt    = data[31:28];
            w_ihl_nxt    = data[27:24];
            w_tlen_nxt   = data[15:0];
            w_sum_nxt    = SUM_W'(data[31:16]) + SUM_W'(data[15:0]);
            w_wcnt_nxt   = WCNT_W'(1);
            w_state_nxt  = S_HDR;
        end else begin
            case (r_state)
                S_HDR: begin
                    w_sum_nxt  = w_sum_acc;
                    w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                    case (r_wcnt)
                        WCNT_W'(1): w_frag_nxt    = data[13:0];
                        WCNT_W'(2): w_proto_nxt   = data[23:16];
                        WCNT_W'(3): w_src_cap_nxt = data;
                        WCNT_W'(4): begin
                            w_dst_cap_nxt = data;
                            if (r_ihl > 4'd5) w_state_nxt = S_OPT;
                            else              w_eval      = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_OPT: begin
                    w_sum_nxt  = w_sum_acc;
                    w_wcnt_nxt = r_wcnt + WCNT_W'(1);
                    if (r_wcnt == WCNT_W'(r_ihl - 4'd1)) w_eval = 1'b1;
                end
                S_PAYLOAD: begin
                    w_data_out_nxt  = data;
                    w_wr_en_nxt     = 1'b1;
                    w_start_out_nxt = r_first;
                    w_first_nxt     = 1'b0;
                    w_pcnt_nxt      = r_pcnt - PCNT_W'(1);
                    if (r_pcnt == PCNT_W'(1)) begin
                        w_fin_nxt    = 1'b1;
                        w_hdr_ok_nxt = 1'b0;
                        w_state_nxt  = S_IDLE;
                    end
                end
                default: ;
            endcase

            // Accept/reject decision on the last header word
            if (w_eval) begin
                if (w_accept) begin
                    w_src_ip_nxt  = r_src_cap;
                    w_dest_ip_nxt = w_dst;
                    w_len_ip_nxt  = w_len;
                    w_pcnt_nxt    = w_pcnt;
                    w_first_nxt   = 1'b1;
                    if (w_pcnt == PCNT_W'(0)) begin
                        w_fin_nxt   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_hdr_ok_nxt = 1'b1;
                        w_state_nxt  = S_PAYLOAD;
                    end
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_wcnt      <= '0;
            r_ver       <= '0;
            r_ihl       <= '0;
            r_tlen      <= '0;
            r_frag      <= '0;
            r_proto     <= '0;
            r_sum       <= '0;
            r_src_cap   <= '0;
            r_dst_cap   <= '0;
            r_pcnt      <= '0;
            r_first     <= 1'b0;
            r_src_ip    <= '0;
            r_dest_ip   <= '0;
            r_len_ip    <= '0;
            r_data_out  <= '0;
            r_start_out <= 1'b0;
            r_wr_en     <= 1'b0;
            r_hdr_ok    <= 1'b0;
            r_fin       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wcnt      <= w_wcnt_nxt;
            r_ver       <= w_ver_nxt;
            r_ihl       <= w_ihl_nxt;
            r_tlen      <= w_tlen_nxt;
            r_frag      <= w_frag_nxt;
            r_proto     <= w_proto_nxt;
            r_sum       <= w_sum_nxt;
            r_src_cap   <= w_src_cap_nxt;
            r_dst_cap   <= w_dst_cap_nxt;
            r_pcnt      <= w_pcnt_nxt;
            r_first     <= w_first_nxt;
            r_src_ip    <= w_src_ip_nxt;
            r_dest_ip   <= w_dest_ip_nxt;
            r_len_ip    <= w_len_ip_nxt;
            r_data_out  <= w_data_out_nxt;
            r_start_out <= w_start_out_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_hdr_ok    <= w_hdr_ok_nxt;
            r_fin       <= w_fin_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign src_ip    = r_src_ip;
    assign dest_ip   = r_dest_ip;
    assign len_ip    = r_len_ip;
    assign data_out  = r_data_out;
    assign start_out = r_start_out;
    assign wr_en     = r_wr_en;
    assign hdr_ok    = r_hdr_ok;
    assign fin       = r_fin;
    assign err       = r_err;

endmodule

// File: tb/tb_ipv4_rx_decoder.sv
// Directed bench for ipv4_rx_decoder: checksum-checking instance (a_*) and
// checksum-ignoring instance (b_*) driven by the same stream.
module tb_ipv4_rx_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data;

    logic [31:0] a_src_ip, a_dest_ip, a_data_out;
    logic [15:0] a_len_ip;
    logic        a_start_out, a_wr_en, a_hdr_ok, a_fin, a_err;
    logic [31:0] b_src_ip, b_dest_ip, b_data_out;
    logic [15:0] b_len_ip;
    logic        b_start_out, b_wr_en, b_hdr_ok, b_fin, b_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] h [0:5];
    logic [31:0] p [0:4] = '{32'h04D2_162E, 32'h0013_0000, 32'h4865_6C6C,
                             32'h6F20_576F, 32'h726C_6400};

    ipv4_rx_decoder #(.PROTO_SEL(8'd17), .CHECK_CHKSUM(1'b1)) dut_a (
        .clk(clk), .reset(reset), .data(data), .start(start),
        .src_ip(a_src_ip), .dest_ip(a_dest_ip), .len_ip(a_len_ip),
        .data_out(a_data_out), .start_out(a_start_out), .wr_en(a_wr_en),
        .hdr_ok(a_hdr_ok), .fin(a_fin), .err(a_err)
    );

    ipv4_rx_decoder #(.PROTO_SEL(8'd17), .CHECK_CHKSUM(1'b0)) dut_b (
        .clk(clk), .reset(reset), .data(data), .start(start),
        .src_ip(b_src_ip), .dest_ip(b_dest_ip), .len_ip(b_len_ip),
        .data_out(b_data_out), .start_out(b_start_out), .wr_en(b_wr_en),
        .hdr_ok(b_hdr_ok), .fin(b_fin), .err(b_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Drive one word on the falling edge, then sample just after the rising edge
    task automatic step(input logic [31:0] w, input logic st);
        @(negedge clk);
        data  = w;
        start = st;
        @(posedge clk);
        #1;
    endtask

    task automatic send_hdr(input int first, input int last);
        for (int i = first; i <= last; i++) step(h[i], i == 0);
    endtask

    // Five payload words; each instance either forwards all of them or none
    task automatic run_payload(input string tag, input logic fwd_a, input logic fwd_b);
        for (int i = 0; i < 5; i++) begin
            step(p[i], 1'b0);
            check($sformatf("%s a_wr_en[%0d]", tag, i), 32'(a_wr_en), 32'(fwd_a));
            check($sformatf("%s b_wr_en[%0d]", tag, i), 32'(b_wr_en), 32'(fwd_b));
            check($sformatf("%s a_err[%0d]", tag, i), 32'(a_err), 32'd0);
            if (fwd_a) begin
                check($sformatf("%s a_data[%0d]", tag, i), a_data_out, p[i]);
                check($sformatf("%s a_sop[%0d]", tag, i), 32'(a_start_out), 32'(i == 0));
                check($sformatf("%s a_fin[%0d]", tag, i), 32'(a_fin), 32'(i == 4));
                check($sformatf("%s a_hdr_ok[%0d]", tag, i), 32'(a_hdr_ok), 32'(i != 4));
            end else begin
                check($sformatf("%s a_fin[%0d]", tag, i), 32'(a_fin), 32'd0);
                check($sformatf("%s a_sop[%0d]", tag, i), 32'(a_start_out), 32'd0);
            end
            if (fwd_b) check($sformatf("%s b_fin[%0d]", tag, i), 32'(b_fin), 32'(i == 4));
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst wr_en",  32'(a_wr_en),  32'd0);
        check("rst hdr_ok", 32'(a_hdr_ok), 32'd0);
        check("rst err",    32'(a_err),    32'd0);
        check("rst src_ip", a_src_ip,      32'd0);
        check("rst len_ip", 32'(a_len_ip), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Valid UDP packet, no options
        h = '{32'h4500_0027, 32'h0000_4000, 32'h4011_7950, 32'h9801_331B, 32'h980E_5E4B, 32'h0};
        send_hdr(0, 3);
        check("ok hdr_ok early", 32'(a_hdr_ok), 32'd0);
        send_hdr(4, 4);
        check("ok hdr_ok",  32'(a_hdr_ok), 32'd1);
        check("ok err",     32'(a_err),    32'd0);
        check("ok src_ip",  a_src_ip,      32'h9801_331B);
        check("ok dest_ip", a_dest_ip,     32'h980E_5E4B);
        check("ok len_ip",  32'(a_len_ip), 32'h0013);
        run_payload("ok", 1'b1, 1'b1);
        step(32'hDEAD_BEEF, 1'b0);
        check("ok trailing wr_en", 32'(a_wr_en), 32'd0);
        check("ok trailing fin",   32'(a_fin),   32'd0);

        // Bad checksum: dropped by a, accepted by b
        h[2] = 32'h4011_7951;
        send_hdr(0, 4);
        check("badck a_err",    32'(a_err),    32'd1);
        check("badck a_hdr_ok", 32'(a_hdr_ok), 32'd0);
        check("badck b_err",    32'(b_err),    32'd0);
        check("badck b_hdr_ok", 32'(b_hdr_ok), 32'd1);
        check("badck a_src held", a_src_ip,    32'h9801_331B);
        run_payload("badck", 1'b0, 1'b1);

        // One option word, checksum recomputed
        h = '{32'h4600_002B, 32'h0000_4000, 32'h4011_784C, 32'h9801_331B, 32'h980E_5E4B, 32'h0000_0000};
        send_hdr(0, 4);
        check("opt hdr_ok at w4", 32'(a_hdr_ok), 32'd0);
        check("opt err at w4",    32'(a_err),    32'd0);
        send_hdr(5, 5);
        check("opt hdr_ok",  32'(a_hdr_ok), 32'd1);
        check("opt len_ip",  32'(a_len_ip), 32'h0013);
        check("opt dest_ip", a_dest_ip,     32'h980E_5E4B);
        run_payload("opt", 1'b1, 1'b1);

        // Wrong protocol (checksum valid)
        h = '{32'h4500_0027, 32'h0000_4000, 32'h4006_795B, 32'h9801_331B, 32'h980E_5E4B, 32'h0};
        send_hdr(0, 4);
        check("tcp a_err", 32'(a_err), 32'd1);
        check("tcp b_err", 32'(b_err), 32'd1);
        run_payload("tcp", 1'b0, 1'b0);

        // More-fragments set (checksum valid)
        h = '{32'h4500_0027, 32'h0000_2000, 32'h4011_9950, 32'h9801_331B, 32'h980E_5E4B, 32'h0};
        send_hdr(0, 4);
        check("mf a_err",    32'(a_err),    32'd1);
        check("mf a_hdr_ok", 32'(a_hdr_ok), 32'd0);
        run_payload("mf", 1'b0, 1'b0);

        // Header-only packet
        h = '{32'h4500_0014, 32'h0000_4000, 32'h4011_7963, 32'h9801_331B, 32'h980E_5E4B, 32'h0};
        send_hdr(0, 4);
        check("zero fin",    32'(a_fin),    32'd1);
        check("zero hdr_ok", 32'(a_hdr_ok), 32'd0);
        check("zero len_ip", 32'(a_len_ip), 32'd0);
        check("zero wr_en",  32'(a_wr_en),  32'd0);
        check("zero err",    32'(a_err),    32'd0);
        step(p[0], 1'b0);
        check("zero fin cleared", 32'(a_fin),   32'd0);
        check("zero no fwd",      32'(a_wr_en), 32'd0);

        // Start during payload aborts and restarts on an option packet
        h = '{32'h4500_0027, 32'h0000_4000, 32'h4011_7950, 32'h9801_331B, 32'h980E_5E4B, 32'h0};
        send_hdr(0, 4);
        step(p[0], 1'b0);
        step(p[1], 1'b0);
        check("abort pre wr_en", 32'(a_wr_en), 32'd1);
        h = '{32'h4600_002B, 32'h0000_4000, 32'h4011_784C, 32'h9801_331B, 32'h980E_5E4B, 32'h0000_0000};
        send_hdr(0, 0);
        check("abort err",    32'(a_err),    32'd1);
        check("abort fin",    32'(a_fin),    32'd0);
        check("abort wr_en",  32'(a_wr_en),  32'd0);
        check("abort hdr_ok", 32'(a_hdr_ok), 32'd0);
        send_hdr(1, 5);
        check("restart hdr_ok", 32'(a_hdr_ok), 32'd1);
        check("restart err",    32'(a_err),    32'd0);
        check("restart len_ip", 32'(a_len_ip), 32'h0013);
        run_payload("restart", 1'b1, 1'b1);

        // Asynchronous reset in the middle of the payload
        h = '{32'h4500_0027, 32'h0000_4000, 32'h4011_7950, 32'h9801_331B, 32'h980E_5E4B, 32'h0};
        send_hdr(0, 4);
        step(p[0], 1'b0);
        check("midrst pre wr_en", 32'(a_wr_en), 32'd1);
        @(negedge clk);
        data = p[1];
        #2 reset = 1'b0;
        #1;
        check("midrst wr_en",    32'(a_wr_en),    32'd0);
        check("midrst data_out", a_data_out,      32'd0);
        check("midrst hdr_ok",   32'(a_hdr_ok),   32'd0);
        check("midrst src_ip",   a_src_ip,        32'd0);
        check("midrst len_ip",   32'(a_len_ip),   32'd0);
        check("midrst b_hdr_ok", 32'(b_hdr_ok),   32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(p[2], 1'b0);
        step(p[3], 1'b0);
        check("midrst idle wr_en", 32'(a_wr_en), 32'd0);
        check("midrst idle fin",   32'(a_fin),   32'd0);
        check("midrst idle err",   32'(a_err),   32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
